dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
Sits between the MEM pipeline stage, a secondary DMA/debug port, and the single-ported data memory. Owns the memory's WE/A/ctrl/WD/PC inputs.
After reset it sequences a word-by-word zero-clear of the memory. The pipeline is stalled during the clear.
In normal operation it arbitrates each cycle: the CPU has priority, and a starvation counter guarantees the DMA port forward progress.

Parameters:
ADDRBITS, 12, word-address width of the data memory; the clear walks 2^ADDRBITS words.
MAX_WAIT, 4, number of consecutive denied DMA-request cycles after which DMA preempts the CPU for one cycle.
DMA_PC, 32'hFFFF_FFFC, value driven on dm_pc for DMA and clear accesses (store-log tag).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  MEM stage holds a load/store this cycle.
cpu_we  in  1  CPU store.
cpu_addr  in  32  CPU byte address.
cpu_ctrl  in  3  CPU width/sign control (DM_word/hfwd/byte/ushw/usbt).
cpu_wd  in  32  CPU store data.
cpu_pc  in  32  PC of the MEM-stage instruction.
cpu_rd  out  32  load data; combinational from dm_rd when CPU is granted, else 0.
cpu_stall  out  1  freeze the pipeline; CPU access not performed this cycle.
dma_req  in  1  DMA access request; held stable until granted.
dma_we, dma_addr, dma_ctrl, dma_wd  in  1/32/3/32  DMA access fields.
dma_gnt  out  1  DMA access performed this cycle.
dma_rd  out  32  registered DMA load data.
dma_rvalid  out  1  one-cycle pulse, cycle after a granted DMA read.
dm_we, dm_a, dm_ctrl, dm_wd, dm_pc  out  1/32/3/32/32  drive the data memory.
dm_rd  in  32  data memory combinational read data.
clear_busy  out  1  high while the post-reset clear runs.

Behaviour:
- States: CLEAR, RUN. All registers update on posedge clk.
- On reset:
  - state=CLEAR, clr_cnt=0, wait_cnt=0.
  - dma_rd=0, dma_rvalid=0.
  - Reset overrides everything, including mid-clear (the clear restarts at word 0) and mid-DMA (no rvalid pulse follows).
- CLEAR:
  - Drive dm_we=1, dm_ctrl=DM_word, dm_a={clr_cnt,2'b00}, dm_wd=0, dm_pc=DMA_PC.
  - clr_cnt increments each cycle.
  - When clr_cnt==2^ADDRBITS-1, the next state is RUN.
  - clear_busy=1.
  - cpu_stall=cpu_req.
  - dma_gnt=0, and wait_cnt is held at 0.
  - The clear lasts exactly 2^ADDRBITS cycles.
- RUN grant (combinational):
  - dma_gnt = dma_req && (!cpu_req || wait_cnt==MAX_WAIT).
  - cpu_gnt = cpu_req && !dma_gnt.
  - cpu_stall = cpu_req && dma_gnt.
- RUN mux:
  - The granted requester drives dm_a/dm_ctrl/dm_wd. dm_we equals that requester's we.
  - dm_pc = cpu_pc for the CPU, DMA_PC for DMA.
  - With no grant: dm_we=0, other outputs 0.
  - A stalled CPU store must never assert dm_we.
- wait_cnt:
  - Increments while dma_req && !dma_gnt, saturating at MAX_WAIT.
  - Clears on dma_gnt or !dma_req.
  - Result under continuous contention: CPU gets MAX_WAIT cycles, then DMA gets 1, repeating.
- DMA read:
  - On dma_gnt && !dma_we, dma_rd<=dm_rd and dma_rvalid<=1 next cycle.
  - Otherwise dma_rvalid<=0 and dma_rd holds.
- CPU read: cpu_rd = cpu_gnt ? dm_rd : 0. Zero added latency; stores complete at the grant-cycle edge.
- The memory's internal reset clear remains; this sequencer makes the init explicit and bounded. Both must leave memory at 0.

Decomposition:
- DM_word/DM_hfwd/DM_byte/DM_ushw/DM_usbt encodings stay in the shared macros include.
- Add the state encodings (ARB_CLEAR, ARB_RUN) and the DMA_PC default there.
- One natural sub-module: dm_clear_seq (clr_cnt, done flag, clear-write drive), instantiated in dm_arbiter.

Test Plan:
- Reset 1 cycle, then idle: clear_busy high exactly 4096 cycles, dm_a 0x0000..0x3FFC step 4, dm_wd=0. Then RUN; lw 0x10 returns 0.
- RUN, CPU only: sw 0x1234ABCD to 0x20, then lw 0x20 → cpu_rd=0x1234ABCD same cycle, cpu_stall never high.
- Both requesting continuously, MAX_WAIT=4: grant pattern CPU,CPU,CPU,CPU,DMA repeating. cpu_stall high exactly on DMA cycles; dm_we never reflects the stalled CPU store.
- DMA read of 0x20 with cpu_req=0: dma_gnt same cycle, dma_rvalid one cycle later with dma_rd=0x1234ABCD.
- cpu_req=1 during CLEAR → cpu_stall=1 every cycle until clear_busy falls. dma_req during CLEAR → dma_gnt=0.
- Reset asserted at clear cycle 100: next cycle dm_a=0, and the full 4096-cycle clear reruns. A DMA read in flight at reset gives no rvalid pulse.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access width/sign codes,
// arbiter states, the store-log tag for non-CPU accesses, and the memory
// command bundle driven toward the data memory.
package dm_arbiter_pkg;

    localparam logic [2:0] DM_WORD = 3'd0;
    localparam logic [2:0] DM_HFWD = 3'd1;
    localparam logic [2:0] DM_BYTE = 3'd2;
    localparam logic [2:0] DM_USHW = 3'd3;
    localparam logic [2:0] DM_USBT = 3'd4;

    localparam logic [31:0] DMA_PC_DEFAULT = 32'hFFFF_FFFC;

    typedef enum logic {
        ARB_CLEAR = 1'b0,
        ARB_RUN   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [2:0]  ctrl;
        logic [31:0] wd;
        logic [31:0] pc;
    } dm_cmd_t;

endpackage

// File: rtl/dm_clear_seq.sv
// Post-reset zero-clear walker: steps a word counter across the whole data
// memory and presents the matching zero-write command.
module dm_clear_seq
    import dm_arbiter_pkg::*;
#(
    parameter int          ADDRBITS = 12,
    parameter logic [31:0] DMA_PC   = DMA_PC_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    active,
    output logic    done,
    output dm_cmd_t clr_cmd
);

    logic [ADDRBITS-1:0] clr_cnt;

    // Word counter; wraps to 0 on the last word so it is parked at 0 in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (active) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign done = active && (clr_cnt == {ADDRBITS{1'b1}});

    // Zero-write of the current word, tagged with the non-CPU PC.
    always_comb begin
        clr_cmd      = '0;
        clr_cmd.we   = active;
        clr_cmd.a    = {{(30-ADDRBITS){1'b0}}, clr_cnt, 2'b00};
        clr_cmd.ctrl = DM_WORD;
        clr_cmd.wd   = 32'd0;
        clr_cmd.pc   = DMA_PC;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: runs the post-reset clear, then grants the memory to
// the MEM stage or the DMA/debug port each cycle. CPU wins by default; after
// MAX_WAIT consecutive denied DMA cycles the DMA port preempts for one cycle.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ARB_CLEAR | zero-writing every word; CPU stalled, DMA never granted
//  ARB_RUN   | per-cycle CPU/DMA arbitration with starvation guard
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int          ADDRBITS = 12,
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] DMA_PC   = DMA_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [2:0]  cpu_ctrl,
    input  logic [31:0] cpu_wd,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [2:0]  dma_ctrl,
    input  logic [31:0] dma_wd,
    output logic        dma_gnt,
    output logic [31:0] dma_rd,
    output logic        dma_rvalid,
    output logic        dm_we,
    output logic [31:0] dm_a,
    output logic [2:0]  dm_ctrl,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd,
    output logic        clear_busy
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cpu_gnt;
    logic              clr_done;
    dm_cmd_t           clr_cmd;
    dm_cmd_t           cmd;

    dm_clear_seq #(
        .ADDRBITS (ADDRBITS),
        .DMA_PC   (DMA_PC)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .active  (state == ARB_CLEAR),
        .done    (clr_done),
        .clr_cmd (clr_cmd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grants and memory command mux.
    always_comb begin
        state_nxt  = state;
        dma_gnt    = 1'b0;
        cpu_gnt    = 1'b0;
        cpu_stall  = 1'b0;
        clear_busy = 1'b0;
        cmd        = '0;
        case (state)
            ARB_CLEAR: begin
                clear_busy = 1'b1;
                cpu_stall  = cpu_req;
                cmd        = clr_cmd;
                if (clr_done) begin
                    state_nxt = ARB_RUN;
                end
            end
            ARB_RUN: begin
                dma_gnt   = dma_req && (!cpu_req || (wait_cnt == WAIT_MAX));
                cpu_gnt   = cpu_req && !dma_gnt;
                cpu_stall = cpu_req && dma_gnt;
                if (dma_gnt) begin
                    cmd.we   = dma_we;
                    cmd.a    = dma_addr;
                    cmd.ctrl = dma_ctrl;
                    cmd.wd   = dma_wd;
                    cmd.pc   = DMA_PC;
                end else if (cpu_gnt) begin
                    cmd.we   = cpu_we;
                    cmd.a    = cpu_addr;
                    cmd.ctrl = cpu_ctrl;
                    cmd.wd   = cpu_wd;
                    cmd.pc   = cpu_pc;
                end
            end
            default: begin
                state_nxt = ARB_CLEAR;
            end
        endcase
    end

    assign dm_we   = cmd.we;
    assign dm_a    = cmd.a;
    assign dm_ctrl = cmd.ctrl;
    assign dm_wd   = cmd.wd;
    assign dm_pc   = cmd.pc;
    assign cpu_rd  = cpu_gnt ? dm_rd : 32'd0;

    // Starvation counter: counts denied DMA cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != ARB_RUN || dma_gnt || !dma_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // DMA read return: capture memory data and pulse valid one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_rd     <= 32'd0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_gnt && !dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rd <= dm_rd;
            end
        end
    end

endmodule
